// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and action codes for the PWM action-qualifier stage
package pwm_pkg;
    localparam int WIDTH = 16;
    localparam int ACT_W = 2;
    typedef logic [ACT_W-1:0] act_t;
    localparam act_t ACT_NOTHING = 2'b00;
    localparam act_t ACT_CLEAR   = 2'b01;
    localparam act_t ACT_SET     = 2'b10;
    localparam act_t ACT_TOGGLE  = 2'b11;
endpackage

// File: rtl/pwm_action_apply.sv
// pwm_action_apply: applies one action code to the current pwm level
module pwm_action_apply
    import pwm_pkg::*;
(
    input  logic pwm,
    input  act_t action,
    output logic pwm_next
);
    always_comb
        pwm_next = action == ACT_CLEAR  ? 1'b0 :
                   action == ACT_SET    ? 1'b1 :
                   action == ACT_TOGGLE ? ~pwm : pwm;
endmodule

// File: rtl/pwm_peripheral_comparator.sv
// pwm_peripheral_comparator: shadowed event compares, priority action select
// and registered PWM output, aligned to the counter's next value.
module pwm_peripheral_comparator
    import pwm_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_period,
    input  logic [W-1:0] i_counter,
    input  logic [W-1:0] i_counter_next,
    input  logic [W-1:0] i_compare_a,
    input  logic [W-1:0] i_compare_b,
    input  act_t         i_action_zero,
    input  act_t         i_action_period,
    input  act_t         i_action_compare_a,
    input  act_t         i_action_compare_b,
    output logic         o_pwm,
    output logic         db_pwm,
    output act_t         db_action_zero_active,
    output act_t         db_action_period_active,
    output act_t         db_action_compare_a_active,
    output act_t         db_action_compare_b_active,
    output logic [W-1:0] db_compare_a_value_active,
    output logic [W-1:0] db_compare_b_value_active
);
    logic         load;
    logic [W-1:0] eff_cmp_a;
    logic [W-1:0] eff_cmp_b;
    act_t         eff_zero;
    act_t         eff_period;
    act_t         eff_a;
    act_t         eff_b;
    logic         zero_ev;
    logic         period_ev;
    logic         a_ev;
    logic         b_ev;
    act_t         action;
    logic         pwm_next;

    // settings captured at this edge already govern the wrap to zero
    always_comb begin
        load       = i_counter == i_period;
        eff_cmp_a  = load ? i_compare_a        : db_compare_a_value_active;
        eff_cmp_b  = load ? i_compare_b        : db_compare_b_value_active;
        eff_zero   = load ? i_action_zero      : db_action_zero_active;
        eff_period = load ? i_action_period    : db_action_period_active;
        eff_a      = load ? i_action_compare_a : db_action_compare_a_active;
        eff_b      = load ? i_action_compare_b : db_action_compare_b_active;
        zero_ev    = i_counter_next == '0;
        period_ev  = i_counter_next == i_period;
        a_ev       = i_counter_next == eff_cmp_a && eff_cmp_a <= i_period;
        b_ev       = i_counter_next == eff_cmp_b && eff_cmp_b <= i_period;
        action     = zero_ev   ? eff_zero   :
                     period_ev ? eff_period :
                     a_ev      ? eff_a      :
                     b_ev      ? eff_b      : ACT_NOTHING;
        db_pwm     = i_reset ? 1'b0 : pwm_next;
    end

    pwm_action_apply u_apply (
        .pwm      (o_pwm),
        .action   (action),
        .pwm_next (pwm_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pwm                      <= 1'b0;
            db_action_zero_active      <= ACT_NOTHING;
            db_action_period_active    <= ACT_NOTHING;
            db_action_compare_a_active <= ACT_NOTHING;
            db_action_compare_b_active <= ACT_NOTHING;
            db_compare_a_value_active  <= '0;
            db_compare_b_value_active  <= '0;
        end else begin
            o_pwm <= pwm_next;
            if (load) begin
                db_action_zero_active      <= i_action_zero;
                db_action_period_active    <= i_action_period;
                db_action_compare_a_active <= i_action_compare_a;
                db_action_compare_b_active <= i_action_compare_b;
                db_compare_a_value_active  <= i_compare_a;
                db_compare_b_value_active  <= i_compare_b;
            end
        end
    end
endmodule

// File: tb/tb_pwm_peripheral_comparator.sv
// tb_pwm_peripheral_comparator: directed waveform shapes plus randomized
// settings, all checked against an event-list reference model.
module tb_pwm_peripheral_comparator;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_period, i_counter, i_counter_next, i_compare_a, i_compare_b;
    logic [1:0]  i_action_zero, i_action_period, i_action_compare_a, i_action_compare_b;
    logic        o_pwm, db_pwm;
    logic [1:0]  db_action_zero_active, db_action_period_active;
    logic [1:0]  db_action_compare_a_active, db_action_compare_b_active;
    logic [15:0] db_compare_a_value_active, db_compare_b_value_active;

    int passed = 0;
    int total = 0;
    logic [15:0] cnt;
    logic        m_pwm;
    logic [1:0]  m_act [4];
    logic [15:0] m_ca, m_cb;

    always #5 i_clk = ~i_clk;

    pwm_peripheral_comparator dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_period(i_period),
        .i_counter(i_counter), .i_counter_next(i_counter_next),
        .i_compare_a(i_compare_a), .i_compare_b(i_compare_b),
        .i_action_zero(i_action_zero), .i_action_period(i_action_period),
        .i_action_compare_a(i_action_compare_a), .i_action_compare_b(i_action_compare_b),
        .o_pwm(o_pwm), .db_pwm(db_pwm),
        .db_action_zero_active(db_action_zero_active),
        .db_action_period_active(db_action_period_active),
        .db_action_compare_a_active(db_action_compare_a_active),
        .db_action_compare_b_active(db_action_compare_b_active),
        .db_compare_a_value_active(db_compare_a_value_active),
        .db_compare_b_value_active(db_compare_b_value_active)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cnt=%0d t=%0t)", tag, got, exp, cnt, $time);
    endtask

    // Event list in priority order; the first matching in-range event decides.
    function automatic logic model_next();
        logic        load;
        logic [15:0] ev_val [4];
        logic [1:0]  ev_act [4];
        logic [1:0]  win;
        logic        found;
        if (i_reset) return 1'b0;
        load = i_counter == i_period;
        ev_val[0] = 16'd0;
        ev_val[1] = i_period;
        ev_val[2] = load ? i_compare_a : m_ca;
        ev_val[3] = load ? i_compare_b : m_cb;
        ev_act[0] = load ? i_action_zero      : m_act[0];
        ev_act[1] = load ? i_action_period    : m_act[1];
        ev_act[2] = load ? i_action_compare_a : m_act[2];
        ev_act[3] = load ? i_action_compare_b : m_act[3];
        win = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++)
            if (!found && ev_val[k] <= i_period && i_counter_next == ev_val[k]) begin
                win = ev_act[k];
                found = 1'b1;
            end
        case (win)
            2'd1: return 1'b0;
            2'd2: return 1'b1;
            2'd3: return !m_pwm;
            default: return m_pwm;
        endcase
    endfunction

    task automatic commit(input logic nxt);
        if (i_reset) begin
            m_pwm = 1'b0;
            m_ca = '0;
            m_cb = '0;
            for (int k = 0; k < 4; k++) m_act[k] = 2'd0;
        end else begin
            m_pwm = nxt;
            if (i_counter == i_period) begin
                m_act[0] = i_action_zero;
                m_act[1] = i_action_period;
                m_act[2] = i_action_compare_a;
                m_act[3] = i_action_compare_b;
                m_ca = i_compare_a;
                m_cb = i_compare_b;
            end
        end
    endtask

    // One count: drive counter, check pre-edge values, clock, check registers.
    task automatic cycle(input logic use_mask, input logic [15:0] mask);
        logic nxt;
        i_counter = cnt;
        i_counter_next = (cnt == i_period) ? 16'd0 : cnt + 16'd1;
        #1;
        nxt = model_next();
        chk("db_pwm", {15'd0, db_pwm}, {15'd0, nxt});
        chk("o_pwm", {15'd0, o_pwm}, {15'd0, m_pwm});
        if (use_mask) chk("shape", {15'd0, o_pwm}, {15'd0, mask[cnt[3:0]]});
        @(posedge i_clk);
        commit(nxt);
        #1;
        chk("act_zero", {14'd0, db_action_zero_active}, {14'd0, m_act[0]});
        chk("act_period", {14'd0, db_action_period_active}, {14'd0, m_act[1]});
        chk("act_a", {14'd0, db_action_compare_a_active}, {14'd0, m_act[2]});
        chk("act_b", {14'd0, db_action_compare_b_active}, {14'd0, m_act[3]});
        chk("cmp_a", db_compare_a_value_active, m_ca);
        chk("cmp_b", db_compare_b_value_active, m_cb);
        cnt = i_counter_next;
    endtask

    task automatic setup(input logic [1:0] z, p, a, b, input logic [15:0] ca, cb);
        i_action_zero = z;
        i_action_period = p;
        i_action_compare_a = a;
        i_action_compare_b = b;
        i_compare_a = ca;
        i_compare_b = cb;
    endtask

    // Runs n whole periods; the shape mask applies from period 'from' (1-based).
    task automatic run_periods(input int n, input int from, input logic [15:0] mask);
        for (int p = 1; p <= n; p++)
            for (int c = 0; c <= 15; c++) cycle(p >= from, mask);
    endtask

    initial begin
        logic first;
        i_reset = 1'b1;
        i_period = 16'd15;
        cnt = 16'd0;
        m_pwm = 1'b0;
        m_ca = '0;
        m_cb = '0;
        for (int k = 0; k < 4; k++) m_act[k] = 2'd0;
        setup(2'd0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
        i_counter = 16'd0;
        i_counter_next = 16'd1;
        @(posedge i_clk);
        #1;
        cycle(1'b0, 16'd0);
        chk("reset_pwm", {15'd0, o_pwm}, 16'd0);
        chk("reset_cmp_a", db_compare_a_value_active, 16'd0);
        i_reset = 1'b0;
        cnt = 16'd0;

        setup(2'd2, 2'd1, 2'd0, 2'd0, 16'd0, 16'd0);
        run_periods(6, 3, 16'h7FFF);
        setup(2'd2, 2'd0, 2'd1, 2'd0, 16'd8, 16'd0);
        run_periods(6, 3, 16'h00FF);
        setup(2'd1, 2'd2, 2'd0, 2'd0, 16'd8, 16'd0);
        run_periods(6, 3, 16'h8000);
        setup(2'd1, 2'd0, 2'd2, 2'd0, 16'd8, 16'd0);
        run_periods(6, 3, 16'hFF00);
        setup(2'd0, 2'd0, 2'd1, 2'd2, 16'd8, 16'd4);
        run_periods(6, 3, 16'h00F0);

        setup(2'd2, 2'd0, 2'd1, 2'd0, 16'd8, 16'd4);
        run_periods(3, 3, 16'h00FF);
        for (int c = 0; c < 5; c++) cycle(1'b1, 16'h00FF);
        i_compare_a = 16'd12;
        for (int c = 5; c < 15; c++) cycle(1'b1, 16'h00FF);
        chk("shadow_hold", db_compare_a_value_active, 16'd8);
        cycle(1'b1, 16'h00FF);
        chk("shadow_load", db_compare_a_value_active, 16'd12);
        run_periods(2, 1, 16'h0FFF);

        setup(2'd2, 2'd0, 2'd1, 2'd0, 16'd0, 16'd0);
        run_periods(6, 3, 16'hFFFF);
        setup(2'd3, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
        run_periods(3, 9, 16'd0);
        first = o_pwm;
        run_periods(1, 9, 16'd0);
        chk("toggle", {15'd0, o_pwm}, {15'd0, !first});
        for (int c = 0; c < 7; c++) cycle(1'b0, 16'd0);
        i_reset = 1'b1;
        cycle(1'b0, 16'd0);
        chk("mid_reset_pwm", {15'd0, o_pwm}, 16'd0);
        chk("mid_reset_db_pwm", {15'd0, db_pwm}, 16'd0);
        chk("mid_reset_act", {6'd0, db_action_zero_active, db_action_period_active,
            db_action_compare_a_active, db_action_compare_b_active}, 16'd0);
        chk("mid_reset_cmp", db_compare_a_value_active | db_compare_b_value_active, 16'd0);
        i_reset = 1'b0;

        for (int s = 0; s < 25; s++) begin
            i_reset = 1'b1;
            cycle(1'b0, 16'd0);
            i_reset = 1'b0;
            i_period = 16'($urandom_range(2, 30));
            cnt = 16'd0;
            for (int c = 0; c < 4 * (i_period + 1); c++) begin
                if ($urandom_range(0, 7) == 0)
                    setup(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                          16'($urandom_range(0, i_period + 3)), 16'($urandom_range(0, i_period + 3)));
                i_reset = $urandom_range(0, 63) == 0;
                cycle(1'b0, 16'd0);
                i_reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
